// File: rtl/usb_fs_in_pe_dbuf.sv
// Full-speed USB IN protocol engine with two packet banks per endpoint.
// The fabric fills one bank while the other bank is sent to the host or resent.
module usb_fs_in_pe_dbuf #(
    parameter int NUM_IN_EPS         = 11,
    parameter int MAX_IN_PACKET_SIZE = 32,
    parameter int ACK_TIMEOUT_CYCLES = 96
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NUM_IN_EPS-1:0] i_reset_ep,
    input  logic [6:0]            i_dev_addr,
    output logic [NUM_IN_EPS-1:0] o_in_ep_data_free,
    input  logic [NUM_IN_EPS-1:0] i_in_ep_data_put,
    input  logic [7:0]            i_in_ep_data,
    input  logic [NUM_IN_EPS-1:0] i_in_ep_data_done,
    input  logic [NUM_IN_EPS-1:0] i_in_ep_stall,
    output logic [NUM_IN_EPS-1:0] o_in_ep_acked,
    input  logic                  i_rx_pkt_start,
    input  logic                  i_rx_pkt_end,
    input  logic                  i_rx_pkt_valid,
    input  logic [3:0]            i_rx_pid,
    input  logic [6:0]            i_rx_addr,
    input  logic [3:0]            i_rx_endp,
    input  logic [10:0]           i_rx_frame_num,
    output logic                  o_tx_pkt_start,
    input  logic                  i_tx_pkt_end,
    output logic [3:0]            o_tx_pid,
    output logic                  o_tx_data_avail,
    input  logic                  i_tx_data_get,
    output logic [7:0]            o_tx_data
);
    localparam int LW  = $clog2(MAX_IN_PACKET_SIZE) + 1;
    localparam int PW  = LW - 1;
    localparam int EPW = (NUM_IN_EPS > 1) ? $clog2(NUM_IN_EPS) : 1;
    localparam int TW  = $clog2(ACK_TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RCVD_IN, S_SEND, S_WAIT_ACK} state_t;

    state_t                r_state, w_state_nxt;
    logic [7:0]            r_mem [NUM_IN_EPS][2][MAX_IN_PACKET_SIZE];
    logic [1:0]            r_full [NUM_IN_EPS];
    logic [LW-1:0]         r_len [NUM_IN_EPS][2];
    logic [LW-1:0]         r_put_ptr [NUM_IN_EPS];
    logic [NUM_IN_EPS-1:0] r_fill_sel, r_send_sel, r_toggle, r_stall, r_free, r_acked;
    logic [EPW-1:0]        r_cur_ep;
    logic [LW-1:0]         r_get;
    logic [TW-1:0]         r_timer;
    logic                  r_tx_ended;
    logic [7:0]            r_tx_data;

    logic                  w_tok, w_in, w_setup, w_ack, w_ack_ok, w_timeout, w_ep_rst_cur;
    logic                  w_put_any, w_put_ok, w_get_inc, w_send_full;
    logic [EPW-1:0]        w_put_ep;
    logic [LW-1:0]         w_send_len, w_get_next;
    logic [LW-1:0]         w_ptr_nxt [NUM_IN_EPS];
    logic [NUM_IN_EPS-1:0] w_free_state, w_put_hit, w_commit, w_cur_onehot;
    logic                  w_unused;

    assign w_unused = ^{i_rx_pkt_start, i_rx_frame_num};

    assign w_tok   = i_rx_pkt_end && i_rx_pkt_valid && (i_rx_pid[1:0] == 2'b01) &&
                     (i_rx_addr == i_dev_addr) && ({1'b0, i_rx_endp} < 5'(NUM_IN_EPS));
    assign w_in    = w_tok && (i_rx_pid[3:2] == 2'b10);
    assign w_setup = w_tok && (i_rx_pid[3:2] == 2'b11);
    assign w_ack   = i_rx_pkt_end && i_rx_pkt_valid && (i_rx_pid == 4'b0010);

    assign w_ep_rst_cur = i_reset_ep[r_cur_ep];
    assign w_send_full  = r_full[r_cur_ep][r_send_sel[r_cur_ep]];
    assign w_send_len   = r_len[r_cur_ep][r_send_sel[r_cur_ep]];
    assign w_ack_ok     = (r_state == S_WAIT_ACK) && w_ack && !w_ep_rst_cur;
    assign w_timeout    = (r_state == S_WAIT_ACK) && (r_timer == TW'(ACK_TIMEOUT_CYCLES));
    assign w_get_inc    = i_tx_data_get && o_tx_data_avail;
    assign w_get_next   = (r_state == S_RCVD_IN) ? '0 : r_get + LW'(w_get_inc);

    // Highest-index put wins; the fill side only ever sees one byte per cycle.
    always_comb begin
        w_put_any = 1'b0;
        w_put_ep  = '0;
        for (int n = 0; n < NUM_IN_EPS; n++) begin
            if (i_in_ep_data_put[n]) begin
                w_put_any = 1'b1;
                w_put_ep  = EPW'(n);
            end
        end
    end

    assign w_put_ok = w_put_any && w_free_state[w_put_ep];

    always_comb begin
        for (int n = 0; n < NUM_IN_EPS; n++) begin
            w_free_state[n] = !r_full[n][r_fill_sel[n]] && !r_stall[n];
            w_put_hit[n]    = w_put_ok && (w_put_ep == EPW'(n));
            w_ptr_nxt[n]    = r_put_ptr[n] + (w_put_hit[n] ? LW'(1) : LW'(0));
            w_commit[n]     = !r_full[n][r_fill_sel[n]] &&
                              (i_in_ep_data_done[n] ||
                               (w_put_hit[n] && (w_ptr_nxt[n] == LW'(MAX_IN_PACKET_SIZE))));
            w_cur_onehot[n] = (r_cur_ep == EPW'(n));
        end
    end

    // Per-endpoint bank bookkeeping; ACK and commit always touch opposite banks.
    always_ff @(posedge i_clk) begin
        for (int n = 0; n < NUM_IN_EPS; n++) begin
            if (i_reset || i_reset_ep[n]) begin
                r_full[n]     <= '0;
                r_put_ptr[n]  <= '0;
                r_fill_sel[n] <= 1'b0;
                r_send_sel[n] <= 1'b0;
                r_toggle[n]   <= 1'b0;
                r_stall[n]    <= 1'b0;
                r_free[n]     <= 1'b0;
            end else begin
                r_free[n] <= w_free_state[n];
                if (i_in_ep_stall[n])
                    r_stall[n] <= 1'b1;
                if (w_commit[n]) begin
                    r_full[n][r_fill_sel[n]] <= 1'b1;
                    r_len[n][r_fill_sel[n]]  <= w_ptr_nxt[n];
                    r_fill_sel[n]            <= ~r_fill_sel[n];
                    r_put_ptr[n]             <= '0;
                end else if (w_put_hit[n]) begin
                    r_put_ptr[n] <= w_ptr_nxt[n];
                end
                if (w_ack_ok && (r_cur_ep == EPW'(n))) begin
                    r_full[n][r_send_sel[n]] <= 1'b0;
                    r_send_sel[n]            <= ~r_send_sel[n];
                    r_toggle[n]              <= ~r_toggle[n];
                end
                if (w_setup && (i_rx_endp == 4'(n))) begin
                    r_stall[n]    <= 1'b0;
                    r_toggle[n]   <= 1'b1;
                    r_full[n]     <= '0;
                    r_fill_sel[n] <= 1'b0;
                    r_send_sel[n] <= 1'b0;
                    r_put_ptr[n]  <= '0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_put_ok)
            r_mem[w_put_ep][r_fill_sel[w_put_ep]][r_put_ptr[w_put_ep][PW-1:0]] <= i_in_ep_data;
        r_tx_data <= r_mem[r_cur_ep][r_send_sel[r_cur_ep]][w_get_next[PW-1:0]];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_in) w_state_nxt = S_RCVD_IN;
            S_RCVD_IN:  w_state_nxt = (!r_stall[r_cur_ep] && w_send_full) ? S_SEND : S_IDLE;
            S_SEND:     if (r_get == w_send_len) w_state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (w_ack)
                    w_state_nxt = S_IDLE;
                else if (w_in)
                    w_state_nxt = S_RCVD_IN;
                else if (i_rx_pkt_end || w_timeout)
                    w_state_nxt = S_IDLE;
            end
            default:    w_state_nxt = S_IDLE;
        endcase
        if ((r_state != S_IDLE) && w_ep_rst_cur)
            w_state_nxt = S_IDLE;
    end

    // Rollback needs no action: the bank stays FULL and get restarts in RCVD_IN.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cur_ep   <= '0;
            r_get      <= '0;
            r_timer    <= '0;
            r_tx_ended <= 1'b0;
            r_acked    <= '0;
        end else begin
            r_acked <= w_ack_ok ? (w_cur_onehot & ~i_reset_ep) : '0;
            if (w_state_nxt == S_RCVD_IN)
                r_cur_ep <= i_rx_endp[EPW-1:0];
            r_get <= w_get_next;
            if (r_state == S_RCVD_IN) begin
                r_timer    <= '0;
                r_tx_ended <= 1'b0;
            end else begin
                if (i_tx_pkt_end)
                    r_tx_ended <= 1'b1;
                if ((r_state == S_WAIT_ACK) && r_tx_ended && !w_timeout)
                    r_timer <= r_timer + TW'(1);
            end
        end
    end

    always_comb begin
        o_tx_pkt_start  = (r_state == S_RCVD_IN);
        o_tx_pid        = 4'b0000;
        if (r_state == S_RCVD_IN) begin
            if (r_stall[r_cur_ep])
                o_tx_pid = 4'b1110;
            else if (w_send_full)
                o_tx_pid = {r_toggle[r_cur_ep], 3'b011};
            else
                o_tx_pid = 4'b1010;
        end
        o_tx_data_avail = (r_state == S_SEND) && (r_get < w_send_len);
    end

    assign o_tx_data         = r_tx_data;
    assign o_in_ep_acked     = r_acked;
    assign o_in_ep_data_free = r_free;

endmodule
